// File: rtl/net_egress_arbiter_if.sv
// ============================================================================
// Module   : net_egress_arbiter_if
// Brief    : Per-tenant AXI-stream inputs and shared egress stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface net_egress_arbiter_if #(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 4
);
    localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

    logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]  s_axis_tdata;
    logic [NUM_PORTS*AXIS_DEST_WIDTH-1:0] s_axis_tdest;
    logic [NUM_PORTS*KEEP_W-1:0]          s_axis_tkeep;
    logic [NUM_PORTS-1:0]                 s_axis_tlast;
    logic [NUM_PORTS-1:0]                 s_axis_tvalid;
    logic [NUM_PORTS-1:0]                 s_axis_tready;

    logic [AXIS_BUS_WIDTH-1:0]            m_axis_tdata;
    logic [AXIS_DEST_WIDTH-1:0]           m_axis_tdest;
    logic [KEEP_W-1:0]                    m_axis_tkeep;
    logic                                 m_axis_tlast;
    logic [AXIS_ID_WIDTH-1:0]             m_axis_tid;
    logic                                 m_axis_tvalid;
    logic                                 m_axis_tready;

    // master: the surrounding system (throttlers + MAC); slave: the arbiter
    modport master (
        output s_axis_tdata, s_axis_tdest, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tdest, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tvalid,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tdest, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tdest, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tvalid,
        input  m_axis_tready
    );
endinterface

`default_nettype wire

// File: rtl/net_egress_arbiter.sv
// ============================================================================
// Module   : net_egress_arbiter
// Brief    : Packet-granular round-robin arbiter onto one egress AXI stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_egress_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int MAX_BEATS       = 191
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    net_egress_arbiter_if.slave          axis,
    input  logic [NUM_PORTS-1:0]         port_enable,
    output logic                         grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic [NUM_PORTS-1:0]         err_oversize
);

    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int KEEP_W = AXIS_BUS_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS + 2);

    localparam logic [IDX_W-1:0] IDX_RESET = IDX_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               state_q,     state_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]     beat_cnt_q,  beat_cnt_d;
    logic [NUM_PORTS-1:0] err_q,       err_d;

    logic [NUM_PORTS-1:0] w_req;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_busy;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_hs;
    logic [CNT_W-1:0]     w_cnt_inc;

    // Search starts one past the last served port, so the served port ranks last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [IDX_W-1:0]     last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W:0]   cand;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = {1'b0, last} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
                cand = cand - (IDX_W+1)'(NUM_PORTS);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                pick  = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_req       = axis.s_axis_tvalid & port_enable;
    assign w_pick      = rr_pick(w_req, grant_idx_q);
    assign w_busy      = (state_q == S_BUSY);
    assign w_sel_valid = axis.s_axis_tvalid[grant_idx_q];
    assign w_sel_last  = axis.s_axis_tlast[grant_idx_q];
    assign w_hs        = w_busy & w_sel_valid & axis.m_axis_tready;
    assign w_cnt_inc   = (beat_cnt_q == CNT_SAT) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (|w_req) begin
                    grant_idx_d = w_pick;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_hs) begin
                    beat_cnt_d = w_cnt_inc;
                    if (w_cnt_inc > CNT_LIMIT) begin
                        err_d[grant_idx_q] = 1'b1;
                    end
                    if (w_sel_last) begin
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            grant_idx_q <= IDX_RESET;
            beat_cnt_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
        end
    end

    // Data path is a pure mux; only valid/ready are gated by the grant.
    assign axis.m_axis_tdata  = axis.s_axis_tdata[grant_idx_q*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
    assign axis.m_axis_tdest  = axis.s_axis_tdest[grant_idx_q*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
    assign axis.m_axis_tkeep  = axis.s_axis_tkeep[grant_idx_q*KEEP_W +: KEEP_W];
    assign axis.m_axis_tlast  = w_sel_last;
    assign axis.m_axis_tid    = AXIS_ID_WIDTH'(grant_idx_q);
    assign axis.m_axis_tvalid = w_busy & w_sel_valid;

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tready
            assign axis.s_axis_tready[i] = w_busy && (grant_idx_q == IDX_W'(i)) && axis.m_axis_tready;
        end
    endgenerate

    assign grant_valid  = w_busy;
    assign grant_idx    = grant_idx_q;
    assign err_oversize = err_q;

endmodule

`default_nettype wire

// File: tb/tb_net_egress_arbiter.sv
// ============================================================================
// Module   : tb_net_egress_arbiter
// Brief    : Scenario and randomized checks of net_egress_arbiter against a
//            packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_net_egress_arbiter;
    localparam int NP   = 4;
    localparam int W    = 64;
    localparam int KW   = W / 8;
    localparam int IDW  = 4;
    localparam int DW   = 4;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] port_enable;
    logic          grant_valid;
    logic [1:0]    grant_idx;
    logic [NP-1:0] err_oversize;

    int total = 0;
    int bad   = 0;

    net_egress_arbiter_if #(.NUM_PORTS(NP), .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW),
                            .AXIS_DEST_WIDTH(DW)) bus ();

    net_egress_arbiter #(.NUM_PORTS(NP), .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW),
                         .AXIS_DEST_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .aclk         (clk),
        .aresetn      (rst_n),
        .axis         (bus),
        .port_enable  (port_enable),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .err_oversize (err_oversize)
    );

    always #5 clk = ~clk;

    // Sources: each port holds a queue of packet lengths; the head is in flight.
    int            len_q[NP][$];
    int            beat_no[NP];
    int            pkt_no[NP];
    bit            want_valid[NP];
    logic [NP-1:0] src_valid;
    logic          mready;

    // Packet-level reference state
    bit            m_busy;
    int            m_g;
    int            m_cnt;
    logic [NP-1:0] m_err;
    int            m_done;
    int            obs[$];

    bit            exp_gv;
    int            exp_gi;
    bit            exp_mv;
    logic [NP-1:0] exp_sr;
    logic [W-1:0]  exp_data;
    logic [KW-1:0] exp_keep;
    logic [DW-1:0] exp_dest;
    bit            exp_last;

    function automatic logic [W-1:0] f_data(int p, int k, int b);
        return {8'(p), 8'(k), 16'(b), 32'(p*977 + k*131 + b*7) ^ 32'hA5A5_5A5A};
    endfunction

    function automatic logic [KW-1:0] f_keep(int p, int k, int b);
        return KW'(p*37 + k*11 + b*3 + 1);
    endfunction

    function automatic logic [DW-1:0] f_dest(int p, int k);
        return DW'(p + 3*k);
    endfunction

    function automatic int rr_next(logic [NP-1:0] req, int last);
        for (int k = 1; k <= NP; k++) begin
            if (req[(last + k) % NP]) return (last + k) % NP;
        end
        return last;
    endfunction

    function automatic bit head_is_last(int p);
        if (len_q[p].size() == 0) return 1'b0;
        return beat_no[p] == len_q[p][0] - 1;
    endfunction

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            len_q[p].delete();
            beat_no[p]    = 0;
            pkt_no[p]     = 0;
            want_valid[p] = 1'b0;
        end
        mready = 1'b0;
        m_busy = 1'b0;
        m_g    = NP - 1;
        m_cnt  = 0;
        m_err  = '0;
        m_done = 0;
        obs.delete();
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            src_valid[p] = (len_q[p].size() > 0) && want_valid[p];
            bus.s_axis_tdata[p*W +: W]   = f_data(p, pkt_no[p], beat_no[p]);
            bus.s_axis_tkeep[p*KW +: KW] = f_keep(p, pkt_no[p], beat_no[p]);
            bus.s_axis_tdest[p*DW +: DW] = f_dest(p, pkt_no[p]);
            bus.s_axis_tlast[p]          = head_is_last(p);
        end
        bus.s_axis_tvalid = src_valid;
        bus.m_axis_tready = mready;
    endtask

    task automatic compute_expect();
        exp_gv = m_busy;
        exp_gi = m_g;
        exp_mv = m_busy && src_valid[m_g];
        exp_sr = '0;
        if (m_busy && mready) exp_sr[m_g] = 1'b1;
        exp_data = f_data(m_g, pkt_no[m_g], beat_no[m_g]);
        exp_keep = f_keep(m_g, pkt_no[m_g], beat_no[m_g]);
        exp_dest = f_dest(m_g, pkt_no[m_g]);
        exp_last = head_is_last(m_g);
    endtask

    // Called just after the clock edge, using the inputs held during the cycle.
    task automatic advance_model();
        if (!m_busy) begin
            if ((src_valid & port_enable) != '0) begin
                m_g    = rr_next(src_valid & port_enable, m_g);
                m_busy = 1'b1;
            end
        end else if (src_valid[m_g] && mready) begin
            m_cnt = (m_cnt + 1 > MAXB + 1) ? MAXB + 1 : m_cnt + 1;
            if (m_cnt > MAXB) m_err[m_g] = 1'b1;
            if (head_is_last(m_g)) begin
                void'(len_q[m_g].pop_front());
                beat_no[m_g] = 0;
                pkt_no[m_g]++;
                m_busy = 1'b0;
                m_cnt  = 0;
                m_done++;
            end else begin
                beat_no[m_g]++;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        advance_model();
        @(negedge clk);
    endtask

    task automatic record_obs();
        if (bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast) obs.push_back(int'(bus.m_axis_tid));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_all();
        port_enable = '1;
        drive_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        port_enable = '1;
        mready      = 1'b1;
        for (int p = 0; p < NP; p++) begin
            len_q[p].push_back(2);
            want_valid[p] = 1'b1;
        end
        drive_inputs();
        #1;
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_gv got=%0b want=0", grant_valid); end
        total++; if (grant_idx !== 2'd3) begin bad++; $display("FAIL reset_gidx got=%0d want=3", grant_idx); end
        total++; if (err_oversize !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b want=0000", err_oversize); end
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%0b want=0", bus.m_axis_tvalid); end
        total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL reset_sready got=%b want=0000", bus.s_axis_tready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_port();
        bit act;
        logic [NP-1:0] want_sr;
        apply_reset();
        len_q[0].push_back(4);
        want_valid[0] = 1'b1;
        mready        = 1'b1;
        for (int c = 0; c < 7; c++) begin
            drive_inputs();
            #1;
            act     = (c >= 1 && c <= 4);
            want_sr = {3'b000, act};
            total++; if (bus.m_axis_tvalid !== act) begin bad++; $display("FAIL single_mvalid c=%0d got=%0b want=%0b", c, bus.m_axis_tvalid, act); end
            total++; if (grant_valid !== act) begin bad++; $display("FAIL single_gv c=%0d got=%0b want=%0b", c, grant_valid, act); end
            total++; if (bus.s_axis_tready !== want_sr) begin bad++; $display("FAIL single_sready c=%0d got=%b want=%b", c, bus.s_axis_tready, want_sr); end
            if (act) begin
                total++; if (bus.m_axis_tid !== 4'd0) begin bad++; $display("FAIL single_tid c=%0d got=%0d want=0", c, bus.m_axis_tid); end
                total++; if (bus.m_axis_tdata !== f_data(0, 0, c - 1)) begin bad++; $display("FAIL single_data c=%0d got=%h want=%h", c, bus.m_axis_tdata, f_data(0, 0, c - 1)); end
                total++; if (bus.m_axis_tlast !== (c == 4)) begin bad++; $display("FAIL single_last c=%0d got=%0b want=%0b", c, bus.m_axis_tlast, c == 4); end
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        bit act;
        int order[6];
        order = '{0, 1, 3, 0, 1, 3};
        apply_reset();
        foreach (order[i]) if (i < 3) begin
            len_q[order[i]].push_back(2);
            len_q[order[i]].push_back(2);
            want_valid[order[i]] = 1'b1;
        end
        mready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_inputs();
            #1;
            compute_expect();
            act = (c < 18) && (c % 3 != 0);
            total++; if (bus.m_axis_tvalid !== act) begin bad++; $display("FAIL cont_mvalid c=%0d got=%0b want=%0b", c, bus.m_axis_tvalid, act); end
            if (act) begin
                total++; if (bus.m_axis_tdata !== exp_data || bus.m_axis_tid !== IDW'(exp_gi)) begin bad++; $display("FAIL cont_beat c=%0d got=%h/%0d want=%h/%0d", c, bus.m_axis_tdata, bus.m_axis_tid, exp_data, exp_gi); end
            end
            record_obs();
            next_cycle();
        end
        total++; if (obs.size() != 6) begin bad++; $display("FAIL cont_count got=%0d want=6", obs.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < obs.size()) begin
                total++; if (obs[i] != order[i]) begin bad++; $display("FAIL cont_order i=%0d got=%0d want=%0d", i, obs[i], order[i]); end
            end
        end
    endtask

    task automatic test_enable_mask();
        apply_reset();
        port_enable = 4'b1101;
        len_q[1].push_back(3);
        len_q[2].push_back(3);
        want_valid[1] = 1'b1;
        want_valid[2] = 1'b1;
        mready        = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) port_enable = 4'b1111;
            drive_inputs();
            #1;
            compute_expect();
            total++; if (bus.s_axis_tready !== exp_sr) begin bad++; $display("FAIL mask_sready c=%0d got=%b want=%b", c, bus.s_axis_tready, exp_sr); end
            if (c < 8) begin
                total++; if (bus.s_axis_tready[1] !== 1'b0) begin bad++; $display("FAIL mask_port1 c=%0d got=%0b want=0", c, bus.s_axis_tready[1]); end
            end
            record_obs();
            next_cycle();
        end
        total++; if (obs.size() != 2) begin bad++; $display("FAIL mask_count got=%0d want=2", obs.size()); end
        if (obs.size() == 2) begin
            total++; if (obs[0] != 2 || obs[1] != 1) begin bad++; $display("FAIL mask_order got=%0d,%0d want=2,1", obs[0], obs[1]); end
        end
    endtask

    task automatic test_backpressure();
        bit pat[8];
        int nb;
        logic [NP-1:0] want_sr;
        pat = '{0, 1, 0, 0, 1, 1, 0, 0};
        nb  = 0;
        apply_reset();
        len_q[2].push_back(3);
        want_valid[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mready = pat[c];
            drive_inputs();
            #1;
            want_sr    = '0;
            want_sr[2] = (c >= 1 && c <= 5) ? pat[c] : 1'b0;
            total++; if (bus.s_axis_tready !== want_sr) begin bad++; $display("FAIL bp_sready c=%0d got=%b want=%b", c, bus.s_axis_tready, want_sr); end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                total++; if (bus.m_axis_tdata !== f_data(2, 0, nb)) begin bad++; $display("FAIL bp_data c=%0d got=%h want=%h", c, bus.m_axis_tdata, f_data(2, 0, nb)); end
                nb++;
            end
            next_cycle();
        end
        total++; if (nb != 3) begin bad++; $display("FAIL bp_beats got=%0d want=3", nb); end
    endtask

    task automatic test_oversize();
        int nb;
        logic [NP-1:0] want_err;
        nb = 0;
        apply_reset();
        len_q[1].push_back(10);
        want_valid[1] = 1'b1;
        mready        = 1'b1;
        for (int c = 0; c < 13; c++) begin
            drive_inputs();
            #1;
            want_err = (c >= 10) ? 4'b0010 : 4'b0000;
            total++; if (err_oversize !== want_err) begin bad++; $display("FAIL ovs_err c=%0d got=%b want=%b", c, err_oversize, want_err); end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                total++; if (bus.m_axis_tdata !== f_data(1, 0, nb)) begin bad++; $display("FAIL ovs_data c=%0d got=%h want=%h", c, bus.m_axis_tdata, f_data(1, 0, nb)); end
                nb++;
            end
            next_cycle();
        end
        total++; if (nb != 10) begin bad++; $display("FAIL ovs_beats got=%0d want=10", nb); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        len_q[0].push_back(6);
        want_valid[0] = 1'b1;
        mready        = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_inputs();
            next_cycle();
        end
        drive_inputs();
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%0b want=1", bus.m_axis_tvalid); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_mvalid got=%0b want=0", bus.m_axis_tvalid); end
        total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL rmid_sready got=%b want=0000", bus.s_axis_tready); end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rmid_gv got=%0b want=0", grant_valid); end
        total++; if (grant_idx !== 2'd3) begin bad++; $display("FAIL rmid_gidx got=%0d want=3", grant_idx); end
        clear_all();
        drive_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        len_q[0].push_back(1);
        len_q[3].push_back(1);
        want_valid[0] = 1'b1;
        want_valid[3] = 1'b1;
        mready        = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_inputs();
            #1;
            if (c == 1) begin
                total++; if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin bad++; $display("FAIL rmid_first got=%0b/%0d want=1/0", grant_valid, grant_idx); end
            end
            record_obs();
            next_cycle();
        end
        total++; if (obs.size() != 2) begin bad++; $display("FAIL rmid_count got=%0d want=2", obs.size()); end
        if (obs.size() == 2) begin
            total++; if (obs[0] != 0 || obs[1] != 3) begin bad++; $display("FAIL rmid_order got=%0d,%0d want=0,3", obs[0], obs[1]); end
        end
    endtask

    task automatic test_random();
        int n_obs;
        n_obs = 0;
        apply_reset();
        for (int c = 0; c < 2500; c++) begin
            if (c % 40 == 0) port_enable = ($urandom_range(0, 2) == 0) ? NP'($urandom) : '1;
            for (int p = 0; p < NP; p++) begin
                if (len_q[p].size() < 2 && $urandom_range(0, 3) == 0) len_q[p].push_back(int'($urandom_range(1, 12)));
                want_valid[p] = ($urandom_range(0, 4) != 0);
            end
            mready = ($urandom_range(0, 9) < 7);
            drive_inputs();
            #1;
            compute_expect();
            total++; if (grant_valid !== exp_gv) begin bad++; $display("FAIL rnd_gv c=%0d got=%0b want=%0b", c, grant_valid, exp_gv); end
            total++; if (grant_idx !== 2'(exp_gi)) begin bad++; $display("FAIL rnd_gidx c=%0d got=%0d want=%0d", c, grant_idx, exp_gi); end
            total++; if (bus.m_axis_tvalid !== exp_mv) begin bad++; $display("FAIL rnd_mvalid c=%0d got=%0b want=%0b", c, bus.m_axis_tvalid, exp_mv); end
            total++; if (bus.s_axis_tready !== exp_sr) begin bad++; $display("FAIL rnd_sready c=%0d got=%b want=%b", c, bus.s_axis_tready, exp_sr); end
            total++; if (err_oversize !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err_oversize, m_err); end
            if (exp_mv) begin
                total++; if (bus.m_axis_tdata !== exp_data) begin bad++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, bus.m_axis_tdata, exp_data); end
                total++; if (bus.m_axis_tkeep !== exp_keep || bus.m_axis_tdest !== exp_dest) begin bad++; $display("FAIL rnd_side c=%0d got=%h/%h want=%h/%h", c, bus.m_axis_tkeep, bus.m_axis_tdest, exp_keep, exp_dest); end
                total++; if (bus.m_axis_tlast !== exp_last || bus.m_axis_tid !== IDW'(exp_gi)) begin bad++; $display("FAIL rnd_last_tid c=%0d got=%0b/%0d want=%0b/%0d", c, bus.m_axis_tlast, bus.m_axis_tid, exp_last, exp_gi); end
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast) n_obs++;
            next_cycle();
        end
        total++; if (n_obs != m_done) begin bad++; $display("FAIL rnd_packets got=%0d want=%0d", n_obs, m_done); end
    endtask

    initial begin
        port_enable = '1;
        clear_all();
        drive_inputs();
        @(negedge clk);
        test_reset();
        test_single_port();
        test_contention();
        test_enable_mask();
        test_backpressure();
        test_oversize();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
